// File: rtl/msk_and_scheduler.sv
// Round-robin issue of NREQ masked-AND requests onto one LAT-cycle gadget; response LAT cycles after issue.
// Issue needs a pending request plus fresh randomness; no response backpressure, tag pipeline never stalls.
module msk_and_scheduler #(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*count*d-1:0]    req_a,
  input  logic [NREQ*count*d-1:0]    req_b,
  input  logic                       rnd_valid,
  output logic                       rnd_ready,
  output logic [count*d-1:0]         gad_ina,
  output logic [count*d-1:0]         gad_inb,
  input  logic [count*d-1:0]         gad_out,
  output logic [NREQ-1:0]            resp_valid,
  output logic [count*d-1:0]         resp_data,
  output logic                       busy
);

  localparam int W  = count * d;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            win_found;
  logic            issue;
  logic [NREQ-1:0] grant;

  logic [LAT-1:0]  stg_vld;
  logic [IW-1:0]   stg_idx [LAT];

  // Search order ptr+1, ptr+2, ... modulo NREQ; first requester holding valid wins.
  always_comb begin
    int sum;
    sum       = 0;
    cand      = '0;
    win_idx   = ptr;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IW'(sum);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign issue     = win_found & rnd_valid;
  assign rnd_ready = issue;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = issue && (win_idx == IW'(i));
    end
  end

  assign req_ready = grant;

  // AND-OR select: shares of different requesters only ever meet through OR with all but one gated to zero.
  always_comb begin
    gad_ina = '0;
    gad_inb = '0;
    for (int i = 0; i < NREQ; i++) begin
      gad_ina = gad_ina | (req_a[i*W +: W] & {W{grant[i]}});
      gad_inb = gad_inb | (req_b[i*W +: W] & {W{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
    end else if (issue) begin
      ptr <= win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        stg_idx[k] <= '0;
      end
    end else begin
      stg_vld[0] <= issue;
      stg_idx[0] <= win_idx;
      for (int k = 1; k < LAT; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_idx[k] <= stg_idx[k-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = stg_vld[LAT-1] && (stg_idx[LAT-1] == IW'(i));
    end
  end

  assign resp_data = gad_out;
  assign busy      = |stg_vld;

endmodule

// File: tb/tb_msk_and_scheduler.sv
// Directed bench for msk_and_scheduler (d=2, count=1, NREQ=4, LAT=2) with a behavioural gadget and a response scoreboard.
module tb_msk_and_scheduler;

  localparam int D    = 2;
  localparam int CNT  = 1;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [1:0] gad_ina;
  logic [1:0] gad_inb;
  logic [1:0] gad_out;
  logic [3:0] resp_valid;
  logic [1:0] resp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         idx;
    logic [1:0] a;
    logic [1:0] b;
    int         due;
  } exp_t;

  exp_t sb[$];

  msk_and_scheduler #(.d(D), .count(CNT), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .gad_ina   (gad_ina),
    .gad_inb   (gad_inb),
    .gad_out   (gad_out),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gadget model: freshly re-masked AND of the unmasked operands, LAT cycles later.
  logic [1:0] gpipe [LAT];
  always @(posedge clk) begin
    logic r;
    r = 1'($urandom);
    gpipe[0] <= {((^gad_ina) & (^gad_inb)) ^ r, r};
    for (int k = 1; k < LAT; k++) gpipe[k] <= gpipe[k-1];
  end
  assign gad_out = gpipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid != 4'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {28'b0, resp_valid}, 32'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_onehot", {28'b0, resp_valid}, 32'(1 << e.idx));
          chk("resp_cycle", cyc, e.due);
          chk("resp_xor", {31'b0, ^resp_data}, {31'b0, (^e.a) & (^e.b)});
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("missing_resp", {28'b0, resp_valid}, 32'(1 << e.idx));
      end
    end
  end

  // One cycle of stimulus; exp_w is the hand-computed winner, -1 for no issue.
  task automatic drive(input logic rst, input logic [3:0] v, input logic rnd,
                       input logic [7:0] aa, input logic [7:0] bb, input int exp_w);
    logic [3:0] exp_rdy;
    logic [1:0] ea;
    logic [1:0] eb;
    @(posedge clk);
    #1;
    rst_n     = rst;
    req_valid = v;
    rnd_valid = rnd;
    req_a     = aa;
    req_b     = bb;
    exp_rdy   = 4'b0;
    ea        = 2'b0;
    eb        = 2'b0;
    if (exp_w >= 0) begin
      exp_rdy = 4'(1 << exp_w);
      ea      = aa[exp_w*2 +: 2];
      eb      = bb[exp_w*2 +: 2];
    end
    @(negedge clk);
    chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
    chk("rnd_ready", {31'b0, rnd_ready}, {31'b0, exp_w >= 0});
    chk("gad_ina", {30'b0, gad_ina}, {30'b0, ea});
    chk("gad_inb", {30'b0, gad_inb}, {30'b0, eb});
    if (!rst) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end else if (exp_w >= 0) begin
      sb.push_back('{idx: exp_w, a: ea, b: eb, due: cyc + LAT});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 4'b0, 1'b0, 8'h00, 8'h00, -1);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'b0, 1'b0, 8'h00, 8'h00, -1);
  endtask

  initial begin
    logic [7:0] aa;
    logic [7:0] bb;
    int         w;
    rst_n     = 1'b0;
    req_valid = 4'b0;
    rnd_valid = 1'b0;
    req_a     = 8'h00;
    req_b     = 8'h00;

    do_reset(1);
    mon_en = 1'b1;
    do_reset(1);
    chk("rst_resp_valid", {28'b0, resp_valid}, 32'b0);
    chk("rst_busy", {31'b0, busy}, 32'b0);

    // Single request from requester 2, then idle cycles with zeroed gadget inputs.
    drive(1'b1, 4'b0100, 1'b1, 8'b0010_0000, 8'b0011_0000, 2);
    idle(1);
    chk("busy_inflight", {31'b0, busy}, 32'd1);
    idle(3);
    chk("busy_drained", {31'b0, busy}, 32'b0);

    // Round robin from reset: 0,1,2,3,0,1.
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      aa = 8'($urandom);
      bb = 8'($urandom);
      drive(1'b1, 4'hF, 1'b1, aa, bb, i % 4);
    end
    // Randomness starvation: no grants, pointer holds at 1, resumes at 2 then 3.
    for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, 1'b0, 8'hA5, 8'h5A, -1);
    drive(1'b1, 4'hF, 1'b1, 8'h9C, 8'h63, 2);
    drive(1'b1, 4'hF, 1'b1, 8'h9C, 8'h63, 3);
    // Wrap: ptr=3 with only requesters 1 and 3 valid picks 1.
    drive(1'b1, 4'b1010, 1'b1, 8'hFF, 8'h0F, 1);
    idle(3);

    // Functional truth table over all 16 share combinations, rotating requesters.
    for (int i = 0; i < 16; i++) begin
      w  = i % 4;
      aa = 8'($urandom);
      bb = 8'($urandom);
      aa[w*2 +: 2] = i[1:0];
      bb[w*2 +: 2] = i[3:2];
      drive(1'b1, 4'(1 << w), 1'b1, aa, bb, w);
    end
    idle(3);

    // Reset mid-flight: cycle-0 result lands before reset; cycle-1 result is discarded.
    do_reset(1);
    drive(1'b1, 4'b0001, 1'b1, 8'h03, 8'h01, 0);
    drive(1'b1, 4'b0010, 1'b1, 8'h04, 8'h0C, 1);
    drive(1'b0, 4'b0000, 1'b0, 8'h00, 8'h00, -1);
    idle(1);
    chk("midrst_resp_c3", {28'b0, resp_valid}, 32'b0);
    chk("midrst_busy_c3", {31'b0, busy}, 32'b0);
    idle(1);
    chk("midrst_resp_c4", {28'b0, resp_valid}, 32'b0);

    // Back-to-back from requester 1: five pulses returned in issue order.
    for (int i = 0; i < 5; i++) begin
      aa = 8'($urandom);
      bb = 8'($urandom);
      aa[3:2] = i[1:0];
      bb[3:2] = ~i[2:1];
      drive(1'b1, 4'b0010, 1'b1, aa, bb, 1);
    end
    idle(4);

    chk("sb_empty", sb.size(), 32'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
